// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, runs the req/ack read handshake to
// instruction memory and buffers returned words in a small {pc, inst} prefetch queue.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] fpc_r, fpc_s, addr_s, target_s, fpc_inc_s;
  logic              req_s;
  logic [ADDR_W-1:0] pc_q_r   [QDEPTH];
  logic [INST_W-1:0] inst_q_r [QDEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r, count_s;
  logic              valid_s, ack_ok_s, enq_s, deq_s, space_s;

  // Queue bookkeeping: which acks are kept, what leaves the head, and room for one more request.
  always_comb begin
    valid_s   = (count_r != {CW{1'b0}});
    ack_ok_s  = mem_ack_i && (state_r == ST_WAIT) && !redirect_i;
    enq_s     = ack_ok_s;
    deq_s     = valid_s && !stall_i && !redirect_i;
    target_s  = {redirect_pc_i[ADDR_W-1:2], redirect_pc_i[1:0] & 2'b00};
    fpc_inc_s = fpc_r + ADDR_W'(3'd4);
    count_s   = count_r;
    if (redirect_i) begin
      count_s = {CW{1'b0}};
    end else begin
      case ({enq_s, deq_s})
        2'b10:   count_s = count_r + CW'(1'b1);
        2'b01:   count_s = count_r - CW'(1'b1);
        default: count_s = count_r;
      endcase
    end
    space_s = (count_s < CW'(QDEPTH));
  end

  // Fetch FSM: next state, next request/address and fetch PC.
  always_comb begin
    state_s = state_r;
    req_s   = mem_req_o;
    addr_s  = mem_addr_o;
    fpc_s   = fpc_r;
    if (redirect_i) begin
      fpc_s = target_s;
      case (state_r)
        ST_IDLE: begin
          state_s = ST_WAIT;
          req_s   = 1'b1;
          addr_s  = target_s;
        end
        ST_WAIT, ST_DROP: begin
          // An outstanding request must still complete; its data is thrown away.
          if (mem_ack_i) begin
            state_s = ST_WAIT;
            req_s   = 1'b1;
            addr_s  = target_s;
          end else begin
            state_s = ST_DROP;
            req_s   = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          req_s   = 1'b0;
          addr_s  = RESET_PC;
        end
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (space_s) begin
            state_s = ST_WAIT;
            req_s   = 1'b1;
            addr_s  = fpc_r;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (mem_ack_i) begin
            fpc_s = fpc_inc_s;
            if (space_s) begin
              addr_s = fpc_inc_s;
            end else begin
              state_s = ST_IDLE;
              req_s   = 1'b0;
            end
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (mem_ack_i) begin
            if (space_s) begin
              state_s = ST_WAIT;
              addr_s  = fpc_r;
            end else begin
              state_s = ST_IDLE;
              req_s   = 1'b0;
            end
          end else begin
            state_s = ST_DROP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          req_s   = 1'b0;
          addr_s  = RESET_PC;
        end
      endcase
    end
  end

  // State, fetch PC, request outputs and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      fpc_r      <= RESET_PC;
      mem_req_o  <= 1'b0;
      mem_addr_o <= RESET_PC;
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
    end else begin
      state_r    <= state_s;
      fpc_r      <= fpc_s;
      mem_req_o  <= req_s;
      mem_addr_o <= addr_s;
      count_r    <= count_s;
      if (redirect_i) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (enq_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1'b1);
        end
        if (deq_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1'b1);
        end
      end
    end
  end

  // Queue storage; the entry's PC is the address that was on the bus when it was acked.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pc_q_r[i]   <= {ADDR_W{1'b0}};
        inst_q_r[i] <= NOP;
      end
    end else if (enq_s) begin
      pc_q_r[wr_ptr_r]   <= mem_addr_o;
      inst_q_r[wr_ptr_r] <= mem_data_i;
    end
  end

  // Head decode from registered queue state only.
  always_comb begin
    valid_o = valid_s;
    if (valid_s) begin
      pc_o   = pc_q_r[rd_ptr_r];
      inst_o = inst_q_r[rd_ptr_r];
    end else begin
      pc_o   = {ADDR_W{1'b0}};
      inst_o = NOP;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: zero-wait streaming, stall fill, slow memory,
// redirects (outstanding, same-cycle ack, with full queue) and mid-transaction reset.
module tb_inst_fetch;

  localparam logic [31:0] MASK = 32'hA5A5_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_addr;

  inst_fetch #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(32'h0000_0100),
    .QDEPTH  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .valid_o      (valid_o),
    .pc_o         (pc_o),
    .inst_o       (inst_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    step(); step();
    chk("rst_req",   {31'h0, mem_req_o}, 32'h0);
    chk("rst_addr",  mem_addr_o, 32'h0000_0100);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_pc",    pc_o, 32'h0);
    chk("rst_inst",  inst_o, NOP);

    rst = 1'b0;
    step();
    chk("first_req",  {31'h0, mem_req_o}, 32'h1);
    chk("first_addr", mem_addr_o, 32'h0000_0100);

    // zero-wait memory: one instruction per cycle
    for (int i = 0; i < 6; i++) begin
      exp_addr = 32'h0000_0100 + 32'(i * 4);
      chk("zw_addr", mem_addr_o, exp_addr);
      chk("zw_req", {31'h0, mem_req_o}, 32'h1);
      mem_ack_i  = 1'b1;
      mem_data_i = mem_addr_o ^ MASK;
      step();
      chk("zw_valid", {31'h0, valid_o}, 32'h1);
      chk("zw_pc",    pc_o, exp_addr);
      chk("zw_inst",  inst_o, exp_addr ^ MASK);
    end

    // stall for 6 cycles: queue fills, request drops, head held
    stall_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_ack_i  = mem_req_o;
      mem_data_i = mem_addr_o ^ MASK;
      step();
      chk("stall_pc",    pc_o, 32'h0000_0114);
      chk("stall_valid", {31'h0, valid_o}, 32'h1);
      chk("stall_req",   {31'h0, mem_req_o}, 32'h0);
    end
    stall_i   = 1'b0;
    mem_ack_i = 1'b0;
    step();
    chk("rel_pc1",   pc_o, 32'h0000_0118);
    chk("rel_inst1", inst_o, 32'h0000_0118 ^ MASK);
    chk("rel_addr",  mem_addr_o, 32'h0000_011C);
    chk("rel_req",   {31'h0, mem_req_o}, 32'h1);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h0000_011C ^ MASK;
    step();
    chk("rel_pc2",   pc_o, 32'h0000_011C);
    chk("rel_inst2", inst_o, 32'h0000_011C ^ MASK);

    // 3-cycle ack latency: valid once every 4 cycles, NOP in between
    for (int k = 0; k < 2; k++) begin
      exp_addr = 32'h0000_0120 + 32'(k * 4);
      for (int j = 0; j < 4; j++) begin
        chk("lat_addr", mem_addr_o, exp_addr);
        chk("lat_req",  {31'h0, mem_req_o}, 32'h1);
        mem_ack_i  = (j == 3);
        mem_data_i = mem_addr_o ^ MASK;
        step();
        if (j < 3) begin
          chk("lat_valid0", {31'h0, valid_o}, 32'h0);
          chk("lat_nop",    inst_o, NOP);
        end else begin
          chk("lat_valid1", {31'h0, valid_o}, 32'h1);
          chk("lat_pc",     pc_o, exp_addr);
          chk("lat_inst",   inst_o, exp_addr ^ MASK);
        end
      end
    end

    // redirect to 0x203 while the request to 0x128 is outstanding; ack 2 cycles later
    mem_ack_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203;
    step();
    redirect_i = 1'b0;
    chk("rd_valid1", {31'h0, valid_o}, 32'h0);
    chk("rd_hold1",  mem_addr_o, 32'h0000_0128);
    chk("rd_req1",   {31'h0, mem_req_o}, 32'h1);
    step();
    chk("rd_valid2", {31'h0, valid_o}, 32'h0);
    chk("rd_hold2",  mem_addr_o, 32'h0000_0128);
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0128 ^ MASK;
    step();
    chk("rd_drop_valid", {31'h0, valid_o}, 32'h0);
    chk("rd_tgt_addr",   mem_addr_o, 32'h0000_0200);
    chk("rd_tgt_req",    {31'h0, mem_req_o}, 32'h1);
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0200 ^ MASK;
    step();
    chk("rd_first_valid", {31'h0, valid_o}, 32'h1);
    chk("rd_first_pc",    pc_o, 32'h0000_0200);
    chk("rd_first_inst",  inst_o, 32'h0000_0200 ^ MASK);

    // redirect in the same cycle as an ack
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0204 ^ MASK;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
    step();
    redirect_i = 1'b0;
    chk("ra_valid", {31'h0, valid_o}, 32'h0);
    chk("ra_addr",  mem_addr_o, 32'h0000_0300);
    chk("ra_req",   {31'h0, mem_req_o}, 32'h1);
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0300 ^ MASK;
    step();
    chk("ra_pc",   pc_o, 32'h0000_0300);
    chk("ra_inst", inst_o, 32'h0000_0300 ^ MASK);

    // redirect together with stall and a full queue
    stall_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'h0000_0304 ^ MASK;
    step();
    chk("rs_full_req", {31'h0, mem_req_o}, 32'h0);
    chk("rs_head_pc",  pc_o, 32'h0000_0300);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0400; mem_ack_i = 1'b0;
    step();
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("rs_valid", {31'h0, valid_o}, 32'h0);
    chk("rs_addr",  mem_addr_o, 32'h0000_0400);
    chk("rs_req",   {31'h0, mem_req_o}, 32'h1);
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0400 ^ MASK;
    step();
    chk("rs_pc",   pc_o, 32'h0000_0400);
    chk("rs_inst", inst_o, 32'h0000_0400 ^ MASK);

    // reset while in WAIT, then a stray ack
    mem_ack_i = 1'b0; rst = 1'b1;
    step();
    chk("rr_req",   {31'h0, mem_req_o}, 32'h0);
    chk("rr_valid", {31'h0, valid_o}, 32'h0);
    chk("rr_addr",  mem_addr_o, 32'h0000_0100);
    rst = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    step();
    chk("rr_stray_valid", {31'h0, valid_o}, 32'h0);
    chk("rr_req2",        {31'h0, mem_req_o}, 32'h1);
    chk("rr_addr2",       mem_addr_o, 32'h0000_0100);
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0100 ^ MASK;
    step();
    chk("rr_pc",   pc_o, 32'h0000_0100);
    chk("rr_inst", inst_o, 32'h0000_0100 ^ MASK);
    mem_ack_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
